// File: rtl/rp_cmd_stream_decoder.sv
// Host command front-end for hardware-in-the-loop runs: decodes single-byte
// commands, drives the DUT input bus/reset/clock-enable and streams sampled outputs.
module rp_cmd_stream_decoder #(
  parameter int INPUT_BYTES  = 4,
  parameter int OUTPUT_WORDS = 1,
  parameter int STEP_CYCLES  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                cmd_data,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic [7:0]                rsp_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [INPUT_BYTES*8-1:0]  dut_in,
  input  logic [OUTPUT_WORDS*32-1:0] dut_out,
  output logic                      dut_rst,
  output logic                      dut_ce,
  output logic                      halted,
  output logic                      error,
  output logic [7:0]                err_code
);

  localparam int IW = INPUT_BYTES * 8;
  localparam int OW = OUTPUT_WORDS * 32;
  localparam int CW = 16;

  localparam logic [7:0] CMD_SAMPLE    = 8'd104;
  localparam logic [7:0] CMD_HALT      = 8'd105;
  localparam logic [7:0] CMD_RST_SET   = 8'd106;
  localparam logic [7:0] CMD_RST_CLR   = 8'd107;
  localparam logic [7:0] CMD_STEP      = 8'd108;
  localparam logic [7:0] CMD_LOAD      = 8'd109;

  localparam logic [CW-1:0] LOAD_LAST  = CW'(INPUT_BYTES - 1);
  localparam logic [CW-1:0] STEP_INIT  = CW'(STEP_CYCLES);
  localparam logic [CW-1:0] SEND_INIT  = CW'(OUTPUT_WORDS * 4);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_STEP = 3'd2,
    S_SEND = 3'd3,
    S_HALT = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   shadow_q;
  logic [IW-1:0]   shadow_d;
  logic [IW-1:0]   dut_in_q;
  logic [OW-1:0]   send_q;
  logic [CW-1:0]   cnt_q;
  logic            rsp_valid_q;
  logic            dut_rst_q;
  logic            dut_ce_q;
  logic            halted_q;
  logic            error_q;
  logic [7:0]      err_code_q;
  logic            cmd_fire_s;
  logic            rsp_fire_s;

  // Command acceptance depends on state alone so the host never sees a valid->ready loop.
  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready = 1'b1;
      S_LOAD:  cmd_ready = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // First payload byte ends up least significant once all bytes have shifted in.
  assign shadow_d   = (shadow_q >> 8) | (IW'(cmd_data) << (IW - 8));
  assign cmd_fire_s = cmd_valid & cmd_ready;
  assign rsp_fire_s = rsp_valid_q & rsp_ready;

  // Decoder FSM with all host- and DUT-facing outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      dut_in_q    <= '0;
      send_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      dut_rst_q   <= 1'b1;
      dut_ce_q    <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_fire_s) begin
            case (cmd_data)
              CMD_RST_SET: dut_rst_q <= 1'b1;
              CMD_RST_CLR: dut_rst_q <= 1'b0;
              CMD_STEP: begin
                state_q  <= S_STEP;
                cnt_q    <= STEP_INIT;
                dut_ce_q <= 1'b1;
              end
              CMD_LOAD: begin
                state_q <= S_LOAD;
                cnt_q   <= '0;
              end
              CMD_SAMPLE: begin
                state_q     <= S_SEND;
                send_q      <= dut_out;
                cnt_q       <= SEND_INIT;
                rsp_valid_q <= 1'b1;
              end
              CMD_HALT: begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
              end
              default: begin
                state_q    <= S_ERR;
                error_q    <= 1'b1;
                err_code_q <= cmd_data;
              end
            endcase
          end
        end
        S_LOAD: begin
          if (cmd_fire_s) begin
            shadow_q <= shadow_d;
            if (cnt_q == LOAD_LAST) begin
              dut_in_q <= shadow_d;
              state_q  <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        S_STEP: begin
          if (cnt_q <= 16'd1) begin
            dut_ce_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_SEND: begin
          if (rsp_fire_s) begin
            send_q <= send_q >> 8;
            if (cnt_q <= 16'd1) begin
              rsp_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
        end
        S_HALT: halted_q <= 1'b1;
        S_ERR:  error_q  <= 1'b1;
        default: begin
          // An unreachable encoding is treated as a fault and parks the block.
          state_q     <= S_ERR;
          error_q     <= 1'b1;
          dut_ce_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_data  = send_q[7:0];
  assign rsp_valid = rsp_valid_q;
  assign dut_in    = dut_in_q;
  assign dut_rst   = dut_rst_q;
  assign dut_ce    = dut_ce_q;
  assign halted    = halted_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule

// File: doc/rp_cmd_stream_decoder.md
Name: rp_cmd_stream_decoder

Overview:
Synthesizable command front-end for hardware-in-the-loop runs of compiled modules.
- Consumes the host byte stream on a valid/ready channel and decodes the single-byte command set: 104 sample, 105 halt, 106/107 reset assert/deassert, 108 step, 109 load inputs.
- Drives the DUT's flattened input bus, reset and clock-enable.
- Serializes sampled DUT outputs back to the host on a byte channel.

Parameters:
INPUT_BYTES, 4, bytes per load command; dut_in width is INPUT_BYTES*8
OUTPUT_WORDS, 1, 32-bit words of DUT output returned per sample command
STEP_CYCLES, 3, clk cycles dut_ce is held high per step command (1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
cmd_data  input  8  host command/payload byte
cmd_valid  input  1  cmd_data valid
cmd_ready  output  1  decoder accepts cmd_data this cycle
rsp_data  output  8  response byte to host
rsp_valid  output  1  rsp_data valid
rsp_ready  input  1  host accepts rsp_data
dut_in  output  INPUT_BYTES*8  flattened DUT input bus
dut_out  input  OUTPUT_WORDS*32  flattened DUT output bus
dut_rst  output  1  DUT reset, active-high
dut_ce  output  1  DUT clock enable
halted  output  1  halt command received
error  output  1  unexpected command received
err_code  output  8  offending command byte

Behaviour:
- Reset (rst=0, async): state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, dut_in=0, shadow=0, dut_rst=1, dut_ce=0, halted=0, error=0, err_code=0. Reset mid-load, mid-step or mid-send discards all progress; no partial byte is emitted after reset.
- Handshake:
  - A byte transfers on a rising edge with valid&ready.
  - rsp_valid/rsp_data hold stable until rsp_ready.
  - cmd_ready is combinational from state only, never from cmd_valid.
- States: IDLE, LOAD, STEP, SEND, HALT, ERR.
- IDLE (cmd_ready=1). Action on accepted byte c:
  - 106: dut_rst=1 from next cycle; stay IDLE.
  - 107: dut_rst=0 from next cycle; stay IDLE.
  - 108: go STEP, load step counter with STEP_CYCLES.
  - 109: go LOAD, clear byte counter.
  - 104: capture dut_out into send shift register on the same edge; go SEND, byte counter = OUTPUT_WORDS*4.
  - 105: go HALT.
  - Any other value, including 110/111 (unsupported in hardware): go ERR, err_code=c.
- LOAD (cmd_ready=1):
  - Each accepted byte is shifted into shadow: shadow <= {byte, shadow[top:8]}, so the first byte received ends up least significant.
  - On the INPUT_BYTES-th byte, dut_in <= shifted value on the same edge (atomic commit; dut_in never shows partial data), then return to IDLE.
  - LOAD payload bytes are never decoded as commands.
- STEP (cmd_ready=0): dut_ce=1 for exactly STEP_CYCLES consecutive cycles starting the cycle after the 108 accept, then IDLE with dut_ce=0.
- SEND (cmd_ready=0):
  - rsp_valid=1 from the cycle after the 104 accept.
  - Byte order: word 0 first, each word little-endian (bits 7:0 first).
  - Shift on each rsp_ready; after the last byte transfers, rsp_valid=0 next cycle and return to IDLE.
  - Back-pressure of any length is legal.
- HALT: halted=1, cmd_ready=0, terminal until reset.
- ERR: error=1, err_code holds c, cmd_ready=0, terminal until reset.
- Minimum command latency is 1 cycle: back-to-back commands in IDLE are accepted every cycle (e.g. 106,107 on consecutive cycles gives dut_rst 1 then 0).
- dut_ce is never high outside STEP. dut_rst changes only on 106/107 or reset, so it is unaffected by LOAD, STEP and SEND.

Test Plan:
- Reset release, then drive 107 -> dut_rst 1->0 one cycle after accept; cmd_ready stays 1; all other outputs remain at reset values.
- Drive 109,0x11,0x22,0x33,0x44 (INPUT_BYTES=4) -> dut_in=0x44332211 one cycle after the 4th byte and 0 before it; dut_in holds while 106 is issued.
- Drive 108 with STEP_CYCLES=3 -> dut_ce high exactly 3 cycles; cmd_ready=0 for those 3 cycles, then 1.
- dut_out=0xDEADBEEF, drive 104, hold rsp_ready low 5 cycles then high -> bytes EF,BE,AD,DE in order; rsp_data stable during stall; rsp_valid drops after DE.
- Drive 0x41 -> error=1, err_code=0x41, cmd_ready=0; further bytes ignored; assert rst low mid-ERR -> all outputs return to reset values.
- Drive 109,0xAA then assert rst -> dut_in=0; after release, 109 plus 4 fresh bytes loads correctly with no stale 0xAA. Separately, drive 105 -> halted=1 and cmd_ready=0 held.
